// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and timer-control outputs shared between the board keys, the
// stopwatch controller (master) and the timer datapath (slave).
interface stopwatch_ctrl_if;
  logic       KEY0;
  logic       KEY1;
  logic       run;
  logic       tick;
  logic       clr;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    input  KEY0, KEY1,
    output run, tick, clr, lap_hold, state
  );

  modport slave (
    output KEY0, KEY1,
    input  run, tick, clr, lap_hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronises and debounces two active-low keys, turns
// presses into events and runs the run/pause/lap/clear FSM plus tick prescaler.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 500_000
) (
  input logic              clk,
  input logic              rst,
  stopwatch_ctrl_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] LAP   = 2'd3;

  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    stable_d;
  logic [CW-1:0] cnt [2];
  logic [1:0]    ev;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          clr_nx;
  logic          run;
  logic          lap_hold;
  logic          clr;
  logic          tick;
  logic [PW-1:0] presc;
  logic          counting;

  // Bit 0 is KEY0, bit 1 is KEY1; levels are active-low, so 1 means released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      stable   <= 2'b11;
      stable_d <= 2'b11;
      cnt[0]   <= '0;
      cnt[1]   <= '0;
    end else begin
      sync1    <= {bus.KEY1, bus.KEY0};
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_LAST) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign ev = stable_d & ~stable;

  // KEY0 wins when both events land in the same cycle.
  always_comb begin
    state_nx = state;
    clr_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (ev[0])      state_nx = RUN;
        else if (ev[1]) clr_nx   = 1'b1;
      end
      RUN: begin
        if (ev[0])      state_nx = PAUSE;
        else if (ev[1]) state_nx = LAP;
      end
      LAP: begin
        if (ev[0])      state_nx = PAUSE;
        else if (ev[1]) state_nx = RUN;
      end
      PAUSE: begin
        if (ev[0]) begin
          state_nx = RUN;
        end else if (ev[1]) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign counting = (state == RUN) || (state == LAP);

  // The prescaler keeps its phase through PAUSE so a resume does not restart the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      run      <= 1'b0;
      lap_hold <= 1'b0;
      clr      <= 1'b0;
      tick     <= 1'b0;
      presc    <= '0;
    end else begin
      state    <= state_nx;
      run      <= (state_nx == RUN) || (state_nx == LAP);
      lap_hold <= (state_nx == LAP);
      clr      <= clr_nx;
      if (counting) begin
        if (presc == PRE_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
          tick  <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        if (state == IDLE || clr_nx) presc <= '0;
      end
    end
  end

  assign bus.state    = state;
  assign bus.run      = run;
  assign bus.lap_hold = lap_hold;
  assign bus.clr      = clr;
  assign bus.tick     = tick;

endmodule
